// File: rtl/pad_half_duplex_ctrl.sv
// pad_half_duplex_ctrl
//   Core-side controller for one PADBID bidirectional pad. Transmits by driving
//   pad_i/pad_oen and receives by sampling pad_c, over a single-wire half-duplex
//   UART-style link: start bit (0), DATA_W data bits LSB first, optional even
//   parity bit, stop bit (1). Guard cycles with the bus released surround every
//   TX frame. A driven bit that reads back differently aborts the frame.
//
//   Optional feature: define PAD_HDX_PARITY_EN to add an even-parity bit
//   (XOR of the data bits) between the data and the stop bit on TX and RX.
//
// Ports
//   CK        in   clock, rising edge
//   RN        in   asynchronous active-low reset
//   tx_valid  in   TX word available
//   tx_data   in   TX word, captured on accept (tx_valid & tx_ready)
//   tx_ready  out  high only in idle while no RX start edge is present
//   rx_valid  out  1-cycle pulse, good frame received
//   rx_data   out  last good RX word, held until the next good frame
//   rx_err    out  1-cycle pulse, framing or parity error
//   col_err   out  1-cycle pulse, collision detected and TX aborted
//   busy      out  controller not idle
//   pad_i     out  to PADBID.I, bit being driven
//   pad_oen   out  to PADBID.OEN, active low
//   pad_c     in   from PADBID.C, pad level
module pad_half_duplex_ctrl #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned BIT_CYC  = 16,
   parameter int unsigned TURN_CYC = 2
) (
   input  logic              CK,
   input  logic              RN,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_err,
   output logic              col_err,
   output logic              busy,
   output logic              pad_i,
   output logic              pad_oen,
   input  logic              pad_c
);

`ifdef PAD_HDX_PARITY_EN
   localparam int unsigned ParW = 1;
`else
   localparam int unsigned ParW = 0;
`endif
   localparam int unsigned FrameW = DATA_W + 2 + ParW;
   localparam int unsigned CntMax = (BIT_CYC > TURN_CYC) ? BIT_CYC : TURN_CYC;
   localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;
   localparam int unsigned BitW   = $clog2(FrameW);

   localparam logic [CntW-1:0] BitLast  = CntW'(BIT_CYC - 1);
   localparam logic [CntW-1:0] TurnLast = CntW'(TURN_CYC - 1);
   // Counting the cycles of a bit from 1, the read-back check falls on cycle
   // BIT_CYC/2+2: mid-bit on the pad plus the two synchroniser stages.
   localparam logic [CntW-1:0] ColChk   = CntW'(BIT_CYC / 2 + 1);
   // RX bit periods are measured from the c_s edge, one cycle before entry.
   localparam logic [CntW-1:0] SampleAt = CntW'(BIT_CYC / 2 - 1);
   localparam logic [BitW-1:0] StopIdx  = BitW'(FrameW - 1);
   localparam logic [BitW-1:0] DataLast = BitW'(DATA_W);

   typedef enum logic [2:0] {StIdle, StTxTurn, StTxBits, StTxRel, StRxBits} state_e;

   state_e              state_q;
   logic [CntW-1:0]     cnt_q;
   logic [BitW-1:0]     bit_q;
   logic                c_meta_q, c_s_q, prev_q;
   logic [FrameW-1:0]   tx_sh_q;
   logic [DATA_W-1:0]   rx_sh_q;
   logic                rx_par_q;
   logic [DATA_W-1:0]   rx_data_q;
   logic                rx_valid_q, rx_err_q, col_err_q, tx_ready_q, busy_q;
   logic                pad_i_q, pad_oen_q;

   logic                start_edge;
   logic [FrameW-1:0]   tx_frame;
   logic [DATA_W:0]     rx_ext;

   assign start_edge = prev_q & ~c_s_q;
   assign rx_ext     = {c_s_q, rx_sh_q};

`ifdef PAD_HDX_PARITY_EN
   assign tx_frame = {1'b1, ^tx_data, tx_data, 1'b0};
`else
   assign tx_frame = {1'b1, tx_data, 1'b0};
`endif

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         bit_q      <= '0;
         c_meta_q   <= 1'b1;
         c_s_q      <= 1'b1;
         prev_q     <= 1'b1;
         tx_sh_q    <= '1;
         rx_sh_q    <= '0;
         rx_par_q   <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         col_err_q  <= 1'b0;
         tx_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         pad_i_q    <= 1'b1;
         pad_oen_q  <= 1'b1;
      end else begin
         c_meta_q   <= pad_c;
         c_s_q      <= c_meta_q;
         // Forced low outside idle: a start edge needs c_s seen high in idle first.
         prev_q     <= (state_q == StIdle) ? c_s_q : 1'b0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         col_err_q  <= 1'b0;
         tx_ready_q <= 1'b0;
         busy_q     <= (state_q != StIdle);
         pad_oen_q  <= (state_q != StTxBits);
         pad_i_q    <= (state_q == StTxBits) ? tx_sh_q[0] : 1'b1;
         cnt_q      <= cnt_q + 1'b1;

         unique case (state_q)
            StIdle: begin
               cnt_q <= '0;
               bit_q <= '0;
               if (start_edge) begin
                  state_q  <= StRxBits;
                  rx_par_q <= 1'b0;
               end else if (tx_valid && tx_ready_q) begin
                  tx_sh_q <= tx_frame;
                  state_q <= StTxTurn;
               end else begin
                  // Ready is withheld in the cycle a start edge becomes visible.
                  tx_ready_q <= ~(c_s_q & ~c_meta_q);
               end
            end

            StTxTurn: begin
               if (cnt_q == TurnLast) begin
                  state_q <= StTxBits;
                  cnt_q   <= '0;
               end
            end

            StTxBits: begin
               if ((cnt_q == ColChk) && (c_s_q != tx_sh_q[0])) begin
                  col_err_q <= 1'b1;
                  state_q   <= StTxRel;
                  cnt_q     <= '0;
                  bit_q     <= '0;
               end else if (cnt_q == BitLast) begin
                  cnt_q   <= '0;
                  tx_sh_q <= {1'b1, tx_sh_q[FrameW-1:1]};
                  if (bit_q == StopIdx) begin
                     state_q <= StTxRel;
                     bit_q   <= '0;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end
            end

            StTxRel: begin
               if (cnt_q == TurnLast) begin
                  state_q    <= StIdle;
                  cnt_q      <= '0;
                  tx_ready_q <= 1'b1;
               end
            end

            StRxBits: begin
               if (cnt_q == BitLast) begin
                  cnt_q <= '0;
                  bit_q <= bit_q + 1'b1;
               end
               if (cnt_q == SampleAt) begin
                  if (bit_q == '0) begin
                     if (c_s_q) begin
                        // Start bit not low at mid-bit: treat as a glitch.
                        state_q    <= StIdle;
                        cnt_q      <= '0;
                        bit_q      <= '0;
                        tx_ready_q <= 1'b1;
                     end
                  end else if (bit_q == StopIdx) begin
                     state_q    <= StIdle;
                     cnt_q      <= '0;
                     bit_q      <= '0;
                     tx_ready_q <= 1'b1;
                     if (c_s_q && !((ParW != 0) && rx_par_q)) begin
                        rx_data_q  <= rx_sh_q;
                        rx_valid_q <= 1'b1;
                     end else begin
                        rx_err_q <= 1'b1;
                     end
                  end else begin
                     // Running XOR over data and parity bits; even parity ends at 0.
                     rx_par_q <= rx_par_q ^ c_s_q;
                     if (bit_q <= DataLast) begin
                        rx_sh_q <= rx_ext[DATA_W:1];
                     end
                  end
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign tx_ready = tx_ready_q;
   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;
   assign rx_err   = rx_err_q;
   assign col_err  = col_err_q;
   assign busy     = busy_q;
   assign pad_i    = pad_i_q;
   assign pad_oen  = pad_oen_q;

endmodule
